nios_practica_noise_gen: RTL

Audio-rate white-noise source driven by the `noise_en` PIO bit of the guitar-practice Nios system. It sits directly downstream of that PIO and upstream of the audio output mixer. The block runs a 32-bit Galois LFSR and attenuates its output by a software-set level. A linear gain ramp on enable and disable prevents clicks. Samples leave through a valid/ready handshake, one sample per audio-rate `sample_tick`.

---
 rtl/nios_practica_noise_gen.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/nios_practica_noise_gen.sv
// -----------------------------------------------------------------------------
// nios_practica_noise_gen
//
// Audio-rate white-noise source. A 32-bit Galois LFSR supplies raw samples.
// Each sample is attenuated by a software-set arithmetic shift and scaled by a
// 0..256 gain. The gain ramps linearly on enable/disable so the output never
// clicks. One sample is produced per sample_tick through a valid/ready port.
//
// Ports:
//   clk          system clock (only clock)
//   reset_n      asynchronous active-low reset
//   noise_en     level enable from the PIO, already in the clk domain
//   sample_tick  single-cycle strobe at the audio sample rate
//   level[3:0]   attenuation as an arithmetic right shift 0..15
//   out_data     signed 16-bit noise sample
//   out_valid    out_data holds an unconsumed sample
//   out_ready    consumer accepts the sample
//   busy         registered "state is not IDLE"
//   drop         one-cycle pulse: a tick was lost to backpressure
//   dbg_state    current FSM state (IDLE=0, RAMP_UP=1, ON=2, RAMP_DOWN=3)
//
// Handshake: a sample is transferred on every rising clk edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// out_data is held stable. A new emission in the same cycle as a transfer
// replaces the sample and keeps out_valid high.
// -----------------------------------------------------------------------------
module nios_practica_noise_gen #(
  parameter int          RAMP_STEP = 1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        noise_en,
  input  logic        sample_tick,
  input  logic [3:0]  level,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        drop,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [9:0]  STEP = 10'(RAMP_STEP);
  localparam logic [9:0]  FULL = 10'd256;

  state_t             state, state_n;
  logic [8:0]         gain, gain_n;
  logic [31:0]        lfsr, lfsr_adv;

  logic               active, blocked, emit, lost;
  logic signed [15:0] raw, scaled;
  logic signed [24:0] scaled_ext, gain_ext, prod;
  logic [15:0]        sample;
  logic [9:0]         gain_sum;
  logic [8:0]         gain_up, gain_dn;

  // Emission control: a tick in an active state either produces a sample or,
  // when the previous sample is still stuck at the consumer, is discarded.
  always_comb begin
    active  = (state != IDLE);
    blocked = out_valid && !out_ready;
    emit    = sample_tick && active && !blocked;
    lost    = sample_tick && active && blocked;
  end

  // Datapath: sample is built from the current LFSR and current gain; both
  // registers advance on the same edge that loads out_data.
  always_comb begin
    lfsr_adv   = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    raw        = $signed(lfsr[15:0]);
    scaled     = raw >>> level;
    scaled_ext = {{9{scaled[15]}}, scaled};
    gain_ext   = $signed({16'b0, gain});
    prod       = scaled_ext * gain_ext;
    // |scaled| <= 2^15 and gain <= 2^8, so bits [23:8] hold the full result.
    sample     = prod[23:8];
  end

  // Saturating gain steps in both directions.
  always_comb begin
    gain_sum = {1'b0, gain} + STEP;
    gain_up  = (gain_sum > FULL) ? 9'd256 : gain_sum[8:0];
    gain_dn  = ({1'b0, gain} <= STEP) ? 9'd0 : (gain - STEP[8:0]);
  end

  // Next-state logic. A tick coinciding with an enable change is processed in
  // the current state (gain step applied) and the direction flips on that
  // same edge.
  always_comb begin
    state_n = state;
    gain_n  = gain;
    case (state)
      IDLE: begin
        if (noise_en) state_n = RAMP_UP;
      end
      RAMP_UP: begin
        if (emit) begin
          gain_n = gain_up;
          if (gain_up == 9'd256) state_n = ON;
        end
        if (!noise_en) state_n = RAMP_DOWN;
      end
      ON: begin
        if (!noise_en) state_n = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (emit) begin
          gain_n = gain_dn;
          if (gain_dn == 9'd0) state_n = IDLE;
        end
        if (noise_en) state_n = RAMP_UP;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gain      <= 9'd0;
      lfsr      <= LFSR_SEED;
      out_data  <= 16'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state <= state_n;
      gain  <= gain_n;
      busy  <= (state_n != IDLE);
      drop  <= lost;
      if (emit) begin
        lfsr      <= lfsr_adv;
        out_data  <= sample;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign dbg_state = state;

endmodule
